// File: rtl/simd_pkg.sv
// -----------------------------------------------------------------------------
// simd_pkg
// Constants shared by the SIMD processor and its instruction server:
// the default instruction-buffer depth, the instruction word width, the
// STOP instruction word returned for out-of-range or idle fetches, and the
// 3-bit opcode encodings.
// -----------------------------------------------------------------------------
package simd_pkg;

  localparam int N       = 512;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] STOP_INSTR = 32'd6;

  localparam logic [2:0] LOAD    = 3'b010;
  localparam logic [2:0] LOAD2   = 3'b011;
  localparam logic [2:0] MULTACC = 3'b100;
  localparam logic [2:0] STORE   = 3'b101;
  localparam logic [2:0] STOP    = 3'b110;

endpackage

// File: rtl/instr_ram.sv
// -----------------------------------------------------------------------------
// instr_ram
// DEPTH x WIDTH instruction buffer: one synchronous write port and one
// registered read port, written so that it maps onto a block RAM.
// Contents are never reset.
//
// Ports
//   clk    : clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address (sampled on the rising edge)
//   rdata  : read data, valid one cycle after raddr
// -----------------------------------------------------------------------------
module instr_ram #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_server.sv
// -----------------------------------------------------------------------------
// instr_server
// Holds a program downloaded by a host and serves it to a processor.
// The host streams words in (valid/ready, last marks the end), then pulses
// RUN; the server raises START_SIGNAL, answers fetches from PC_AXI with one
// cycle of latency and counts run cycles until the processor reports STOP,
// after which DONE pulses for one cycle. The program is kept for reruns.
//
// Ports
//   CLK, RSTN     : clock, asynchronous active-low reset
//   LOAD_VALID    : host offers LOAD_DATA
//   LOAD_DATA     : instruction word from host
//   LOAD_LAST     : final word of the program
//   LOAD_READY    : server accepts a word this cycle
//   RUN           : one-cycle request to execute the loaded program
//   PC_AXI        : processor fetch address
//   INSTR_AXI     : fetched instruction (registered, 1-cycle latency)
//   START_SIGNAL  : enables the processor while running
//   STOP_SIGNAL   : processor has retired STOP
//   DONE          : one-cycle pulse when a run completes
//   BUSY          : server is not idle
//   PROG_LEN      : number of words loaded
//   RUN_CYCLES    : cycles START_SIGNAL was high in the last run
//   ERR_OVF       : sticky, host offered more than N words
// -----------------------------------------------------------------------------
module instr_server #(
  parameter int N = simd_pkg::N
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 LOAD_VALID,
  input  logic [31:0]          LOAD_DATA,
  input  logic                 LOAD_LAST,
  output logic                 LOAD_READY,
  input  logic                 RUN,
  input  logic [$clog2(N)-1:0] PC_AXI,
  output logic [31:0]          INSTR_AXI,
  output logic                 START_SIGNAL,
  input  logic                 STOP_SIGNAL,
  output logic                 DONE,
  output logic                 BUSY,
  output logic [$clog2(N):0]   PROG_LEN,
  output logic [31:0]          RUN_CYCLES,
  output logic                 ERR_OVF
);

  import simd_pkg::*;

  localparam int AW = $clog2(N);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FINISH
  } state_t;

  state_t            state_reg, state_next;
  logic              ready_reg;
  logic [LW-1:0]     prog_len_reg;
  logic [31:0]       run_cycles_reg;
  logic              err_ovf_reg;
  logic              fetch_hit_reg;

  logic              accept;
  logic              full;
  logic              ram_we;
  logic [AW-1:0]     ram_waddr;
  logic [INSTR_W-1:0] ram_rdata;

  assign accept = LOAD_VALID & ready_reg;
  assign full   = (prog_len_reg == LW'(N));

  // Next state and buffer write control
  always_comb begin
    state_next = state_reg;
    ram_we     = 1'b0;
    ram_waddr  = '0;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          // First word of a new program always lands at address 0;
          // a load beats a simultaneous RUN request.
          ram_we     = 1'b1;
          state_next = LOAD_LAST ? S_IDLE : S_LOAD;
        end else if (RUN && (prog_len_reg != '0)) begin
          state_next = S_RUN;
        end
      end
      S_LOAD: begin
        if (accept) begin
          ram_we    = !full;
          ram_waddr = prog_len_reg[AW-1:0];
          if (LOAD_LAST) begin
            state_next = S_IDLE;
          end
        end
      end
      S_RUN: begin
        if (STOP_SIGNAL) begin
          state_next = S_FINISH;
        end
      end
      S_FINISH: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_reg      <= S_IDLE;
      ready_reg      <= 1'b0;
      prog_len_reg   <= '0;
      run_cycles_reg <= '0;
      err_ovf_reg    <= 1'b0;
      fetch_hit_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      // Ready is registered so it comes up one edge after reset release
      // and is low for the whole RUN/FINISH episode.
      ready_reg     <= (state_next == S_IDLE) || (state_next == S_LOAD);
      // Out-of-range fetches return STOP; the range check is registered
      // alongside the RAM read so both line up on the same cycle.
      fetch_hit_reg <= ({1'b0, PC_AXI} < prog_len_reg);
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            prog_len_reg <= LW'(1);
            err_ovf_reg  <= 1'b0;
          end else if (state_next == S_RUN) begin
            run_cycles_reg <= '0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (full) begin
              err_ovf_reg <= 1'b1;
            end else begin
              prog_len_reg <= prog_len_reg + LW'(1);
            end
          end
        end
        S_RUN: begin
          if (run_cycles_reg != '1) begin
            run_cycles_reg <= run_cycles_reg + 32'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  instr_ram #(
    .DEPTH (N),
    .WIDTH (INSTR_W)
  ) u_ram (
    .clk   (CLK),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (LOAD_DATA),
    .raddr (PC_AXI),
    .rdata (ram_rdata)
  );

  // Outside RUN the processor only ever sees STOP.
  assign INSTR_AXI    = ((state_reg == S_RUN) && fetch_hit_reg) ? ram_rdata : STOP_INSTR;
  assign LOAD_READY   = ready_reg;
  assign START_SIGNAL = (state_reg == S_RUN);
  assign DONE         = (state_reg == S_FINISH);
  assign BUSY         = (state_reg != S_IDLE);
  assign PROG_LEN     = prog_len_reg;
  assign RUN_CYCLES   = run_cycles_reg;
  assign ERR_OVF      = err_ovf_reg;

endmodule

// File: doc/instr_server.md
INSTR_SERVER -- requirements
Module: instr_server

Interface
REQ-001 SHALL have parameter N, default 512, meaning instruction-buffer depth; address width is $clog2(N).
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port RSTN  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port LOAD_VALID  input  1  host offers an instruction word.
REQ-005 SHALL have port LOAD_DATA  input  32  instruction word from host.
REQ-006 SHALL have port LOAD_LAST  input  1  marks the final word of the program.
REQ-007 SHALL have port LOAD_READY  output  1  server accepts a word this cycle.
REQ-008 SHALL have port RUN  input  1  single-cycle request to execute the loaded program.
REQ-009 SHALL have port PC_AXI  input  $clog2(N)  processor fetch address.
REQ-010 SHALL have port INSTR_AXI  output  32  instruction returned to the processor.
REQ-011 SHALL have port START_SIGNAL  output  1  GPIO enabling the processor.
REQ-012 SHALL have port STOP_SIGNAL  input  1  GPIO, processor has retired STOP.
REQ-013 SHALL have port DONE  output  1  one-cycle pulse when a run completes.
REQ-014 SHALL have port BUSY  output  1  high in any state other than IDLE.
REQ-015 SHALL have port PROG_LEN  output  $clog2(N)+1  number of words loaded.
REQ-016 SHALL have port RUN_CYCLES  output  32  cycles START_SIGNAL was high in the last run.
REQ-017 SHALL have port ERR_OVF  output  1  sticky: host offered more than N words.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, RUN and FINISH.
REQ-019 IDLE: LOAD_READY=1; the first accepted word (LOAD_VALID&LOAD_READY) SHALL clear PROG_LEN and ERR_OVF, write address 0, and move to LOAD unless LOAD_LAST is set.
REQ-020 LOAD: each accepted word SHALL be written at address PROG_LEN and increment PROG_LEN; LOAD_LAST on an accepted word SHALL return to IDLE.
REQ-021 When PROG_LEN==N, LOAD_READY SHALL stay 1; words SHALL be dropped, ERR_OVF SHALL be set, and PROG_LEN SHALL not wrap.
REQ-022 RUN in IDLE with PROG_LEN>0 SHALL enter RUN and clear RUN_CYCLES; RUN in LOAD, or with PROG_LEN==0, SHALL be ignored.
REQ-023 If RUN and an accepted LOAD_VALID coincide in IDLE, load SHALL win and RUN SHALL be dropped.
REQ-024 RUN: START_SIGNAL=1, LOAD_READY=0, RUN_CYCLES SHALL increment every cycle and saturate at 32'hFFFFFFFF.
REQ-025 INSTR_AXI SHALL be registered with 1-cycle latency: INSTR_AXI(t+1) = mem[PC_AXI(t)] if PC_AXI(t) < PROG_LEN, else STOP_INSTR.
REQ-026 The fetch path SHALL operate in every state; outside RUN, INSTR_AXI SHALL read as STOP_INSTR.
REQ-027 STOP_SIGNAL=1 in RUN SHALL move to FINISH: START_SIGNAL SHALL drop on the next edge and RUN_CYCLES SHALL freeze.
REQ-028 FINISH SHALL last exactly one cycle with DONE=1, then return to IDLE; the program SHALL be retained for reruns.
REQ-029 STOP_SIGNAL outside RUN SHALL be ignored.

Reset
REQ-030 RSTN low SHALL immediately force IDLE, START_SIGNAL=0, LOAD_READY=0 (1 from the first edge after release), DONE=0, BUSY=0, PROG_LEN=0, RUN_CYCLES=0, ERR_OVF=0 and INSTR_AXI=STOP_INSTR.
REQ-031 Buffer contents SHALL NOT be reset; a reset mid-RUN SHALL deassert START_SIGNAL asynchronously and SHALL NOT pulse DONE.

Structure
REQ-032 Shared package simd_pkg SHALL hold N, INSTR_W=32, STOP_INSTR=32'd6 and the opcode constants (LOAD=3'b010, LOAD2=3'b011, MULTACC=3'b100, STORE=3'b101, STOP=3'b110).
REQ-033 The FSM state enum SHALL be local to instr_server.
REQ-034 The buffer SHALL be one sub-module, instr_ram: N x 32, one synchronous write port and one registered read port, inferable as BRAM.

Verification
REQ-035 Load 3 words {32'h2322, 32'h0722, 32'h4} with LAST on the third, then RUN -> PROG_LEN=3, START_SIGNAL=1; PC_AXI=0,1,2,3 returns 32'h2322, 32'h0722, 32'h4, 32'h6, each one cycle later.
REQ-036 Assert STOP_SIGNAL 10 cycles after START_SIGNAL rises -> START_SIGNAL low next edge, DONE pulses once, RUN_CYCLES=10, BUSY=0.
REQ-037 Offer N+2 words with LAST on the last -> PROG_LEN=N, ERR_OVF=1, mem[N-1] holds word N-1.
REQ-038 RUN with PROG_LEN=0, and RUN during LOAD -> no START_SIGNAL, state unchanged.
REQ-039 Drop RSTN low for 1 cycle mid-RUN -> START_SIGNAL low immediately, no DONE, PROG_LEN=0; a reload of 1 word followed by RUN works.
REQ-040 Rerun without reload -> identical fetch data, RUN_CYCLES recounted from 0.
